// File: rtl/hex_fetch.sv
// ---------------------------------------------------------------------------
// hex_fetch -- instruction fetch stage of the hex processor.
//
// Reads 32-bit words from instruction memory (fixed one-cycle read latency),
// splits each word into four little-endian instruction bytes, buffers them
// in a small circular byte queue and hands them to decode one per cycle over
// a valid/ready handshake, together with each byte's PC. A branch redirect
// from execute flushes the queue, drops the read returning in the same
// cycle and restarts fetching at the (possibly unaligned) target.
//
// Parameters
//   IQ_DEPTH  instruction byte queue depth (power of two, >= 8)
//   RESET_PC  byte address fetched after reset (21 bits)
//
// Ports
//   i_clk            clock
//   i_rst            asynchronous, active-high reset
//   o_mem_rd_en      word read request
//   o_mem_rd_addr    word address (byte address [20:2])
//   i_mem_rd_data    read data, valid the cycle after o_mem_rd_en
//   o_instr_valid    o_instr / o_instr_pc hold a valid instruction
//   i_instr_ready    decode accepts; transfer on valid && ready
//   o_instr          instruction byte {opcode[3:0], operand[3:0]}
//   o_instr_pc       byte address of o_instr
//   i_branch         redirect request, one-cycle pulse
//   i_branch_target  redirect byte address, may be unaligned
// ---------------------------------------------------------------------------
module hex_fetch #(
    parameter int unsigned IQ_DEPTH = 8,
    parameter logic [20:0] RESET_PC = 21'h000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_rd_en,
    output logic [18:0] o_mem_rd_addr,
    input  logic [31:0] i_mem_rd_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [7:0]  o_instr,
    output logic [20:0] o_instr_pc,
    input  logic        i_branch,
    input  logic [20:0] i_branch_target
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Issue threshold: a full word must still fit once every read already
    // in flight has landed.
    localparam logic [CNT_W:0] ISSUE_LIMIT = (CNT_W + 1)'(IQ_DEPTH - 4);
    localparam logic [CNT_W:0] DEPTH_MAX   = (CNT_W + 1)'(IQ_DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]       r_q [IQ_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_inflight;   // a read was issued last cycle
    logic [18:0]      r_fetch_addr;
    logic [1:0]       r_skip;       // leading bytes to drop from next word
    logic [20:0]      r_head_pc;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic [CNT_W:0]   w_level;
    logic             w_rd_en;
    logic             w_push;
    logic [2:0]       w_push_n;
    logic             w_valid;
    logic             w_pop;
    logic [CNT_W:0]   w_count_sum;
    logic [CNT_W-1:0] w_count_next;
    logic [3:0]       w_lane_en;
    logic [PTR_W-1:0] w_lane_idx [4];

    always_comb begin
        w_level  = {1'b0, r_count} + (r_inflight ? (CNT_W + 1)'(4) : '0);
        // Reset gating keeps the request low while i_rst is held, since the
        // occupancy test alone would otherwise be true on an empty queue.
        w_rd_en  = (w_level <= ISSUE_LIMIT) && !i_branch && !i_rst;
        // The word returning in a branch cycle belongs to the old stream.
        w_push   = r_inflight && !i_branch;
        w_push_n = 3'd4 - {1'b0, r_skip};
        w_valid  = (r_count != '0);
        w_pop    = w_valid && i_instr_ready && !i_branch;

        w_count_sum = {1'b0, r_count}
                    + (w_push ? (CNT_W + 1)'(w_push_n) : '0)
                    - (w_pop  ? (CNT_W + 1)'(1)        : '0);
        w_count_next = w_count_sum[CNT_W-1:0];

        // Byte lane k lands at wr_ptr + (k - skip); lanes below skip are
        // the part of an unaligned first word that precedes the target.
        for (int k = 0; k < 4; k++) begin
            w_lane_en[k]  = w_push && (2'(k) >= r_skip);
            w_lane_idx[k] = r_wr_ptr + PTR_W'(k) - PTR_W'(r_skip);
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= 1'b0;
            r_fetch_addr <= RESET_PC[20:2];
            r_skip       <= RESET_PC[1:0];
            r_head_pc    <= RESET_PC;
        end else if (i_branch) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= 1'b0;
            r_fetch_addr <= i_branch_target[20:2];
            r_skip       <= i_branch_target[1:0];
            r_head_pc    <= i_branch_target;
        end else begin
            r_inflight <= w_rd_en;
            r_count    <= w_count_next;
            if (w_rd_en) begin
                r_fetch_addr <= r_fetch_addr + 19'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
                r_skip   <= 2'd0;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_head_pc <= r_head_pc + 21'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Byte queue storage (data only, no reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_lane_en[k]) begin
                r_q[w_lane_idx[k]] <= i_mem_rd_data[8*k +: 8];
            end
        end
    end

    // Occupancy can never exceed the queue depth given the issue threshold.
    always @(posedge i_clk) begin
        if (!i_rst && !i_branch) begin
            assert (w_count_sum <= DEPTH_MAX);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_mem_rd_en   = w_rd_en;
    assign o_mem_rd_addr = r_fetch_addr;
    assign o_instr_valid = w_valid;
    // Masked when empty so the byte output reads zero out of reset.
    assign o_instr       = w_valid ? r_q[r_rd_ptr] : 8'h00;
    assign o_instr_pc    = r_head_pc;

endmodule

// File: tb/tb_hex_fetch.sv
module tb_hex_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ready, branch, poison;
    logic [20:0] target;

    logic        rd_en0, rd_en1, v0, v1;
    logic [18:0] addr0, addr1;
    logic [31:0] data0 = 32'h0, data1 = 32'h0;
    logic [7:0]  ins0, ins1;
    logic [20:0] pc0, pc1;

    logic [31:0] mem_words [32];

    hex_fetch #(.IQ_DEPTH(8), .RESET_PC(21'h000000)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .o_mem_rd_en(rd_en0), .o_mem_rd_addr(addr0), .i_mem_rd_data(data0),
        .o_instr_valid(v0), .i_instr_ready(ready), .o_instr(ins0), .o_instr_pc(pc0),
        .i_branch(branch), .i_branch_target(target)
    );

    hex_fetch #(.IQ_DEPTH(8), .RESET_PC(21'h1FFFFC)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .o_mem_rd_en(rd_en1), .o_mem_rd_addr(addr1), .i_mem_rd_data(data1),
        .o_instr_valid(v1), .i_instr_ready(ready), .o_instr(ins1), .o_instr_pc(pc1),
        .i_branch(1'b0), .i_branch_target(21'h0)
    );

    // Instruction memory: one-cycle read latency, optional corrupt word.
    always @(posedge clk) begin
        data0 <= poison ? 32'h99999999 : mem_words[addr0[4:0]];
        data1 <= poison ? 32'h99999999 : mem_words[addr1[4:0]];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [20:0] pc);
        logic [31:0] w;
        w = mem_words[pc[6:2]];
        return w[{pc[1:0], 3'b000} +: 8];
    endfunction

    // Scoreboard of expected {byte, pc} for dut0, consumed on each handshake.
    typedef struct packed {
        logic [7:0]  b;
        logic [20:0] pc;
    } exp_t;
    exp_t sbq[$];

    task automatic sb_fill(input logic [20:0] start, input int n);
        sbq.delete();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc = start + 21'(i);
            e.b  = exp_byte(e.pc);
            sbq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && v0 && ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_instr", 32'(ins0), 32'(e.b));
            chk("sb_pc", 32'(pc0), 32'(e.pc));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        branch = 1'b0;
        poison = 1'b0;
        sbq.delete();
        repeat (2) nxt();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rden0"}, 32'(rd_en0), 32'h0);
        chk({tag, "_addr0"}, 32'(addr0), 32'h0);
        chk({tag, "_valid0"}, 32'(v0), 32'h0);
        chk({tag, "_instr0"}, 32'(ins0), 32'h0);
        chk({tag, "_pc0"}, 32'(pc0), 32'h0);
        chk({tag, "_addr1"}, 32'(addr1), 32'h7FFFF);
        chk({tag, "_pc1"}, 32'(pc1), 32'h1FFFFC);
    endtask

    // Called at the start of cycle 0 with ready held high.
    task automatic check_startup();
        logic [20:0] epc;
        sb_fill(21'h0, 12);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("c0_rden0", 32'(rd_en0), 32'h1);
                chk("c0_addr0", 32'(addr0), 32'h0);
                chk("c0_valid0", 32'(v0), 32'h0);
                chk("c0_rden1", 32'(rd_en1), 32'h1);
                chk("c0_addr1", 32'(addr1), 32'h7FFFF);
            end else if (c == 1) begin
                chk("c1_rden0", 32'(rd_en0), 32'h1);
                chk("c1_addr0", 32'(addr0), 32'h1);
                chk("c1_valid0", 32'(v0), 32'h0);
                chk("c1_rden1", 32'(rd_en1), 32'h1);
                chk("c1_addr1", 32'(addr1), 32'h0);
            end else if (c < 10) begin
                if (c == 2) chk("c2_valid0", 32'(v0), 32'h1);
                epc = 21'h1FFFFC + 21'(c - 2);
                chk("wrap_valid1", 32'(v1), 32'h1);
                chk("wrap_pc1", 32'(pc1), 32'(epc));
                chk("wrap_instr1", 32'(ins1), 32'(exp_byte(epc)));
            end
            nxt();
        end
        chk("startup_drained", sbq.size(), 32'h0);
    endtask

    typedef struct {
        logic [20:0] tgt;
        logic [18:0] addr;
        logic [7:0]  instr;
        int          pre_stall;
        logic        rdy;
    } br_vec_t;
    br_vec_t vecs [6];

    int rdcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int w = 0; w < 32; w++) begin
            mem_words[w] = {8'(w*4+3), 8'(w*4+2), 8'(w*4+1), 8'(w*4)};
        end
        mem_words[0] = 32'h44332211;
        mem_words[1] = 32'hDDCCBBAA;

        //          target        word addr   byte   stall  ready
        vecs[0] = '{21'h000006, 19'h00001, 8'hCC, 0, 1'b1};
        vecs[1] = '{21'h000013, 19'h00004, 8'h13, 0, 1'b1};
        vecs[2] = '{21'h1FFFFE, 19'h7FFFF, 8'h7E, 0, 1'b1};
        vecs[3] = '{21'h00001F, 19'h00007, 8'h1F, 6, 1'b0};
        vecs[4] = '{21'h000000, 19'h00000, 8'h11, 3, 1'b1};
        vecs[5] = '{21'h000002, 19'h00000, 8'h33, 0, 1'b0};

        rst = 1'b1; ready = 1'b1; branch = 1'b0; target = 21'h0; poison = 1'b0;
        repeat (2) nxt();
        chk_reset_outputs("rst");

        // Reset release, ready held high; dut1 covers address/PC wrap.
        rst = 1'b0;
        check_startup();

        // Decode stalled for 10 cycles: issue stops at a full queue.
        ready = 1'b0;
        do_reset();
        rdcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd_en0) rdcnt++;
            if (c >= 2) begin
                chk("stall_valid", 32'(v0), 32'h1);
                chk("stall_instr", 32'(ins0), 32'h11);
                chk("stall_pc", 32'(pc0), 32'h0);
            end
            nxt();
        end
        chk("stall_rdcnt", rdcnt, 32'd2);
        sb_fill(21'h0, 16);
        ready = 1'b1;
        repeat (22) nxt();
        chk("stall_drained", sbq.size(), 32'h0);

        // Branch while a read is in flight; corrupt returning words.
        ready = 1'b1;
        do_reset();
        poison = 1'b1;
        nxt();
        branch = 1'b1; target = 21'h000009; sbq.delete();
        @(negedge clk);
        chk("inflt_T_rden", 32'(rd_en0), 32'h0);
        nxt();
        branch = 1'b0; poison = 1'b0;
        sb_fill(21'h000009, 8);
        @(negedge clk);
        chk("inflt_T1_rden", 32'(rd_en0), 32'h1);
        chk("inflt_T1_addr", 32'(addr0), 32'h2);
        nxt();
        @(negedge clk);
        chk("inflt_T2_valid", 32'(v0), 32'h0);
        nxt();
        @(negedge clk);
        chk("inflt_T3_valid", 32'(v0), 32'h1);
        chk("inflt_T3_instr", 32'(ins0), 32'h09);
        chk("inflt_T3_pc", 32'(pc0), 32'h9);
        repeat (12) nxt();
        chk("inflt_drained", sbq.size(), 32'h0);

        // Redirect vectors, some taken with a full queue and stalled decode.
        for (int i = 0; i < 6; i++) begin
            ready = 1'b0;
            repeat (vecs[i].pre_stall) nxt();
            ready  = vecs[i].rdy;
            branch = 1'b1;
            target = vecs[i].tgt;
            sbq.delete();
            @(negedge clk);
            chk("br_T_rden", 32'(rd_en0), 32'h0);
            nxt();
            branch = 1'b0;
            sb_fill(vecs[i].tgt, 6);
            @(negedge clk);
            chk("br_T1_rden", 32'(rd_en0), 32'h1);
            chk("br_T1_addr", 32'(addr0), 32'(vecs[i].addr));
            chk("br_T1_valid", 32'(v0), 32'h0);
            nxt();
            @(negedge clk);
            chk("br_T2_valid", 32'(v0), 32'h0);
            nxt();
            @(negedge clk);
            chk("br_T3_valid", 32'(v0), 32'h1);
            chk("br_T3_instr", 32'(ins0), 32'(vecs[i].instr));
            chk("br_T3_pc", 32'(pc0), 32'(vecs[i].tgt));
            nxt();
            ready = 1'b1;
            repeat (10) nxt();
            chk("br_drained", sbq.size(), 32'h0);
        end

        // Back-to-back branches: the second one wins.
        ready = 1'b1;
        branch = 1'b1; target = 21'h000005; sbq.delete();
        nxt();
        target = 21'h00000E;
        @(negedge clk);
        chk("b2b_T_rden", 32'(rd_en0), 32'h0);
        nxt();
        branch = 1'b0;
        sb_fill(21'h00000E, 6);
        @(negedge clk);
        chk("b2b_T1_addr", 32'(addr0), 32'h3);
        nxt();
        nxt();
        @(negedge clk);
        chk("b2b_T3_pc", 32'(pc0), 32'hE);
        repeat (10) nxt();
        chk("b2b_drained", sbq.size(), 32'h0);

        // Reset pulse with the queue half full and a read in flight.
        ready = 1'b0;
        do_reset();
        repeat (2) nxt();
        chk("pre_rst_valid", 32'(v0), 32'h1);
        poison = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async");
        repeat (2) nxt();
        poison = 1'b0;
        ready = 1'b1;
        rst = 1'b0;
        check_startup();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
